// File: rtl/filter_out_sat.sv
// Output conditioning after the FIR engine: round, rescale and saturate each
// channel, then queue the stereo word in a first-word-fall-through FIFO.
module filter_out_sat #(
    parameter int IN_WIDTH  = 40,
    parameter int OUT_WIDTH = 16,
    parameter int SHIFT     = 15,
    parameter int DEPTH     = 4
) (
    input  logic                         clk,
    input  logic                         rstb,
    input  logic                         acc_valid,
    input  logic [IN_WIDTH-1:0]          acc_left,
    input  logic [IN_WIDTH-1:0]          acc_right,
    output logic [2*OUT_WIDTH-1:0]       out_aud,
    output logic                         out_aud_rts,
    input  logic                         out_aud_rtr,
    output logic [$clog2(DEPTH):0]       fifo_count,
    output logic                         sat_flag,
    output logic                         ovf_flag,
    input  logic                         flag_clr
);

    localparam int AW  = $clog2(DEPTH);
    localparam int CW  = AW + 1;
    localparam int SW  = IN_WIDTH + 1;
    localparam int OW2 = 2 * OUT_WIDTH;
    localparam logic [SW-1:0] ROUND_C = SW'(1) << (SHIFT - 1);

    // Shift out the fraction, then clamp if the kept value does not fit OUT_WIDTH.
    // Returns {saturated, sample}.
    function automatic logic [OUT_WIDTH:0] sat_round(input logic [SW-1:0] s);
        logic signed [SW-1:0] q;
        q = $signed(s) >>> SHIFT;
        if ((&q[SW-1:OUT_WIDTH-1]) || (~|q[SW-1:OUT_WIDTH-1])) begin
            return {1'b0, q[OUT_WIDTH-1:0]};
        end else if (q[SW-1]) begin
            return {1'b1, 1'b1, {(OUT_WIDTH-1){1'b0}}};
        end else begin
            return {1'b1, 1'b0, {(OUT_WIDTH-1){1'b1}}};
        end
    endfunction

    logic [SW-1:0]        sum_l_d, sum_l_q, sum_r_d, sum_r_q;
    logic                 v1_d, v1_q, v2_d, v2_q;
    logic [OUT_WIDTH-1:0] dat_l_d, dat_l_q, dat_r_d, dat_r_q;
    logic                 sat_l_d, sat_l_q, sat_r_d, sat_r_q;
    logic [OW2-1:0]       mem_d [DEPTH];
    logic [OW2-1:0]       mem_q [DEPTH];
    logic [AW-1:0]        wr_ptr_d, wr_ptr_q, rd_ptr_d, rd_ptr_q;
    logic [CW-1:0]        cnt_d, cnt_q;
    logic                 rts_d, rts_q;
    logic [OW2-1:0]       out_aud_d, out_aud_q;
    logic                 sat_d, sat_q, ovf_d, ovf_q;
    logic                 pop_s, push_s, drop_s, sat_set_s;

    // Stage 1: sign-extend and add half an output LSB; one extra bit avoids wrap.
    always_comb begin
        sum_l_d = {acc_left[IN_WIDTH-1], acc_left} + ROUND_C;
        sum_r_d = {acc_right[IN_WIDTH-1], acc_right} + ROUND_C;
        v1_d    = acc_valid;
    end

    // Stage 2: rescale and saturate both channels.
    always_comb begin
        {sat_l_d, dat_l_d} = sat_round(sum_l_q);
        {sat_r_d, dat_r_d} = sat_round(sum_r_q);
        v2_d               = v1_q;
    end

    // FIFO bookkeeping; a push into a full FIFO is still taken when a pop frees a slot.
    always_comb begin
        pop_s    = rts_q && out_aud_rtr;
        push_s   = v2_q && ((cnt_q < CW'(DEPTH)) || pop_s);
        drop_s   = v2_q && !push_s;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_s) begin
            mem_d[wr_ptr_q] = {dat_l_q, dat_r_q};
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
        rts_d     = (cnt_d != CW'(0));
        out_aud_d = mem_d[rd_ptr_d];
    end

    // Sticky status flags; a new event wins over a coincident clear.
    always_comb begin
        sat_set_s = v2_q && (sat_l_q || sat_r_q);
        if (sat_set_s) begin
            sat_d = 1'b1;
        end else if (flag_clr) begin
            sat_d = 1'b0;
        end else begin
            sat_d = sat_q;
        end
        if (drop_s) begin
            ovf_d = 1'b1;
        end else if (flag_clr) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rstb) begin
            sum_l_q   <= {SW{1'b0}};
            sum_r_q   <= {SW{1'b0}};
            v1_q      <= 1'b0;
            v2_q      <= 1'b0;
            dat_l_q   <= {OUT_WIDTH{1'b0}};
            dat_r_q   <= {OUT_WIDTH{1'b0}};
            sat_l_q   <= 1'b0;
            sat_r_q   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {OW2{1'b0}};
            end
            wr_ptr_q  <= {AW{1'b0}};
            rd_ptr_q  <= {AW{1'b0}};
            cnt_q     <= {CW{1'b0}};
            rts_q     <= 1'b0;
            out_aud_q <= {OW2{1'b0}};
            sat_q     <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            sum_l_q   <= sum_l_d;
            sum_r_q   <= sum_r_d;
            v1_q      <= v1_d;
            v2_q      <= v2_d;
            dat_l_q   <= dat_l_d;
            dat_r_q   <= dat_r_d;
            sat_l_q   <= sat_l_d;
            sat_r_q   <= sat_r_d;
            mem_q     <= mem_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            cnt_q     <= cnt_d;
            rts_q     <= rts_d;
            out_aud_q <= out_aud_d;
            sat_q     <= sat_d;
            ovf_q     <= ovf_d;
        end
    end

    // Outputs are straight from registers; nothing depends combinationally on out_aud_rtr.
    always_comb begin
        out_aud     = out_aud_q;
        out_aud_rts = rts_q;
        fifo_count  = cnt_q;
        sat_flag    = sat_q;
        ovf_flag    = ovf_q;
    end

endmodule

// File: tb/tb_filter_out_sat.sv
// Directed bench for filter_out_sat: expected words are queued as stimulus is
// issued and a negedge monitor compares every word the DUT hands over.
module tb_filter_out_sat;

    logic               clk = 1'b0;
    logic               rstb;
    logic               acc_valid;
    logic signed [39:0] acc_left, acc_right;
    logic [31:0]        out_aud;
    logic               out_aud_rts;
    logic               out_aud_rtr;
    logic [2:0]         fifo_count;
    logic               sat_flag, ovf_flag, flag_clr;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] sb[$];

    filter_out_sat dut (
        .clk(clk), .rstb(rstb), .acc_valid(acc_valid),
        .acc_left(acc_left), .acc_right(acc_right),
        .out_aud(out_aud), .out_aud_rts(out_aud_rts), .out_aud_rtr(out_aud_rtr),
        .fifo_count(fifo_count), .sat_flag(sat_flag), .ovf_flag(ovf_flag),
        .flag_clr(flag_clr)
    );

    always #5 clk = ~clk;

    // Monitor: a handshake seen at negedge completes at the next posedge.
    always @(negedge clk) begin
        if (rstb && out_aud_rts && out_aud_rtr) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_word actual=%h required=none", out_aud);
            end else begin
                logic [31:0] e;
                e = sb.pop_front();
                if (out_aud !== e) begin
                    errors++;
                    $display("FAIL out_word actual=%h required=%h", out_aud, e);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic logic signed [39:0] mk(input int v);
        logic signed [39:0] x;
        x = 40'(v);
        return x <<< 15;
    endfunction

    task automatic send(input logic signed [39:0] l, input logic signed [39:0] r);
        acc_valid = 1'b1;
        acc_left  = l;
        acc_right = r;
        tick();
        acc_valid = 1'b0;
    endtask

    task automatic expw(input logic [15:0] l, input logic [15:0] r);
        sb.push_back({l, r});
    endtask

    initial begin
        rstb = 1'b0; acc_valid = 1'b0; acc_left = 40'sd0; acc_right = 40'sd0;
        out_aud_rtr = 1'b0; flag_clr = 1'b0;
        repeat (3) tick();
        chk("rst_out_aud", out_aud, 32'h0);
        chk("rst_rts", {31'd0, out_aud_rts}, 32'd0);
        chk("rst_count", {29'd0, fifo_count}, 32'd0);
        chk("rst_sat", {31'd0, sat_flag}, 32'd0);
        chk("rst_ovf", {31'd0, ovf_flag}, 32'd0);
        rstb = 1'b1;
        tick();

        // Passthrough and latency
        out_aud_rtr = 1'b1;
        expw(16'sd1000, -16'sd1000);
        send(mk(1000), mk(-1000));
        chk("lat_e0_rts", {31'd0, out_aud_rts}, 32'd0);
        tick();
        chk("lat_e1_rts", {31'd0, out_aud_rts}, 32'd0);
        tick();
        chk("lat_e2_rts", {31'd0, out_aud_rts}, 32'd1);
        chk("pass_data", out_aud, {16'sd1000, -16'sd1000});
        repeat (3) tick();
        chk("pass_rts_idle", {31'd0, out_aud_rts}, 32'd0);
        chk("pass_sat", {31'd0, sat_flag}, 32'd0);
        chk("pass_ovf", {31'd0, ovf_flag}, 32'd0);

        // Rounding toward +inf at the half-LSB points
        expw(16'sd1, 16'sd0);  send(40'sd16384, 40'sd0);
        expw(16'sd0, 16'sd0);  send(40'sd16383, 40'sd0);
        expw(16'sd0, 16'sd0);  send(-40'sd16384, 40'sd0);
        expw(-16'sd1, 16'sd0); send(-40'sd16385, 40'sd0);
        repeat (5) tick();
        chk("round_drained", {29'd0, fifo_count}, 32'd0);

        // Saturation and sticky flag behaviour
        expw(16'h7FFF, 16'h8000);
        send(40'sh0080000000, -40'sh0080000000);
        tick(); tick();
        chk("sat_set", {31'd0, sat_flag}, 32'd1);
        flag_clr = 1'b1; tick(); flag_clr = 1'b0;
        chk("sat_clr", {31'd0, sat_flag}, 32'd0);
        expw(16'sd32767, -16'sd32768);
        send(mk(32767), mk(-32768));
        repeat (3) tick();
        chk("sat_edge_none", {31'd0, sat_flag}, 32'd0);
        expw(16'h7FFF, 16'sd0);
        send(mk(32767) + 40'sd16384, 40'sd0);
        tick();
        flag_clr = 1'b1; tick(); flag_clr = 1'b0;
        chk("sat_set_wins", {31'd0, sat_flag}, 32'd1);
        flag_clr = 1'b1; tick(); flag_clr = 1'b0;
        chk("sat_clr2", {31'd0, sat_flag}, 32'd0);
        repeat (3) tick();

        // Full FIFO and overflow drop
        out_aud_rtr = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            if (k <= 4) expw(16'(k), 16'sd0);
            send(mk(k), 40'sd0);
        end
        repeat (3) tick();
        chk("full_count", {29'd0, fifo_count}, 32'd4);
        chk("full_ovf", {31'd0, ovf_flag}, 32'd1);
        chk("full_rts", {31'd0, out_aud_rts}, 32'd1);
        out_aud_rtr = 1'b1;
        tick(); tick();
        chk("drain_half", {29'd0, fifo_count}, 32'd2);
        tick(); tick();
        chk("drain_count", {29'd0, fifo_count}, 32'd0);
        chk("drain_rts", {31'd0, out_aud_rts}, 32'd0);
        flag_clr = 1'b1; tick(); flag_clr = 1'b0;
        chk("ovf_clr", {31'd0, ovf_flag}, 32'd0);

        // Push and pop at the same edge while full
        out_aud_rtr = 1'b0;
        for (int k = 10; k <= 13; k++) begin
            expw(16'(k), 16'sd0);
            send(mk(k), 40'sd0);
        end
        repeat (3) tick();
        chk("pp_full", {29'd0, fifo_count}, 32'd4);
        expw(16'sd14, 16'sd0);
        send(mk(14), 40'sd0);
        tick();
        out_aud_rtr = 1'b1; tick(); out_aud_rtr = 1'b0;
        chk("pp_count", {29'd0, fifo_count}, 32'd4);
        chk("pp_ovf", {31'd0, ovf_flag}, 32'd0);
        out_aud_rtr = 1'b1;
        repeat (6) tick();
        chk("pp_drained", {29'd0, fifo_count}, 32'd0);

        // Reset with two entries queued and one in stage 2
        out_aud_rtr = 1'b0;
        send(40'sh0080000000, 40'sd0);
        send(mk(21), 40'sd0);
        send(mk(22), 40'sd0);
        tick();
        chk("pre_rst_count", {29'd0, fifo_count}, 32'd2);
        chk("pre_rst_sat", {31'd0, sat_flag}, 32'd1);
        rstb = 1'b0; tick(); rstb = 1'b1;
        chk("mid_rst_rts", {31'd0, out_aud_rts}, 32'd0);
        chk("mid_rst_count", {29'd0, fifo_count}, 32'd0);
        chk("mid_rst_sat", {31'd0, sat_flag}, 32'd0);
        chk("mid_rst_ovf", {31'd0, ovf_flag}, 32'd0);
        out_aud_rtr = 1'b1;
        repeat (6) tick();
        chk("post_rst_rts", {31'd0, out_aud_rts}, 32'd0);
        expw(16'sd7, 16'sd7);
        send(mk(7), mk(7));
        repeat (5) tick();

        chk("sb_empty", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/filter_out_sat.md
# filter_out_sat

Output conditioning stage directly downstream of the FIR filter state machine. It consumes the two signed 40-bit per-channel accumulator results once per filtered sample. Each channel is rounded, rescaled from Q15 coefficient gain and saturated to 16 bits. The resulting 32-bit stereo word is buffered in a small FIFO and presented to the next audio stage on a ready-to-send / ready-to-receive handshake.

## Interface
- IN_WIDTH, 40: accumulator width per channel (signed).
- OUT_WIDTH, 16: output sample width per channel (signed).
- SHIFT, 15: arithmetic right shift applied after rounding (Q15 coefficients).
- DEPTH, 4: output FIFO entries; power of two, minimum 2.

- clk  in  1  single clock, all logic on rising edge.
- rstb  in  1  reset, synchronous, active-low.
- acc_valid  in  1  one-cycle strobe: acc_left/acc_right hold a completed sum.
- acc_left  in  IN_WIDTH  signed left-channel accumulator.
- acc_right  in  IN_WIDTH  signed right-channel accumulator.
- out_aud  out  2*OUT_WIDTH  {left, right} head of FIFO.
- out_aud_rts  out  1  ready to send: FIFO non-empty.
- out_aud_rtr  in  1  ready to receive from downstream.
- fifo_count  out  clog2(DEPTH)+1  current occupancy.
- sat_flag  out  1  sticky: any channel saturated.
- ovf_flag  out  1  sticky: a sample was dropped because the FIFO was full.
- flag_clr  in  1  clears sat_flag and ovf_flag.

## Operation
- Stage 1 (registered), per channel: sum = sign-extended acc + 2^(SHIFT-1), computed at IN_WIDTH+1 bits with no wrap. The valid bit is v1.
- Stage 2 (registered), per channel:
  - q = sum >>> SHIFT (arithmetic).
  - q > 2^(OUT_WIDTH-1)-1 gives 32767 (at the default width); q < -2^(OUT_WIDTH-1) gives -32768; otherwise q[OUT_WIDTH-1:0].
  - The per-channel saturate bit is registered with the data. The valid bit is v2.
- Rounding is round-half-up toward +inf: +0.5 LSB rounds up, -0.5 LSB rounds to 0.
- FIFO push = v2.
  - The push is accepted if fifo_count < DEPTH, or if a pop occurs in the same cycle.
  - Otherwise the sample is dropped, ovf_flag is set, and FIFO contents are unchanged.
- Pop = out_aud_rts && out_aud_rtr. The FIFO is first-word fall-through: out_aud = mem[rdptr], valid whenever out_aud_rts = 1.
  - When out_aud_rts = 0, out_aud holds the last addressed entry; it is don't-care to the consumer.
- Simultaneous push and pop: both happen and fifo_count is unchanged. Pointers wrap modulo DEPTH.
- sat_flag is set when v2 = 1 and either channel saturated, even if that sample is dropped.
- Flag set and flag_clr in the same cycle: set wins.
- Pipeline never stalls; throughput is one sample per clock. A back-to-back acc_valid is legal.
- acc_valid with no prior activity needs no state machine or control sequencing beyond the valid pipeline.

## Timing
- Reset value of every output: out_aud = 0, out_aud_rts = 0, fifo_count = 0, sat_flag = 0, ovf_flag = 0.
- Reset also clears v1, v2, FIFO pointers and memory.
- Latency: acc_valid sampled at edge E0 → stage 1 at E0 → stage 2 at E1 → FIFO write at E2. out_aud_rts = 1 and out_aud valid after E2 when the FIFO was empty.
- out_aud_rts and fifo_count are registered-state outputs with no combinational path from out_aud_rtr.
- A pop at edge E removes the head; the next entry appears on out_aud after E.
- rstb low mid-burst: at the next edge everything returns to reset values, in-flight samples are discarded, and no pop or push is reported.
- flag_clr takes effect at the next edge.

## Test plan
- Passthrough: acc_left = 1000·2^15, acc_right = -1000·2^15, out_aud_rtr = 1 → out_aud = {16'd1000, -16'sd1000} with out_aud_rts high exactly after the third edge counted from sampling; flags stay 0.
- Rounding: acc_left = 16384, 16383, -16384, -16385 on successive cycles → left outputs 1, 0, 0, -1 in order, one per cycle.
- Saturation: acc_left = 2^31, acc_right = -2^31 → out_aud = {32767, -32768}, sat_flag = 1. Then flag_clr pulse → sat_flag = 0. flag_clr coincident with another saturating sample → sat_flag remains 1.
- Full/overflow: out_aud_rtr = 0, six back-to-back acc_valid with left values 1..6 → fifo_count = 4, ovf_flag = 1. Then out_aud_rtr = 1 → left values 1, 2, 3, 4 delivered on consecutive cycles, then out_aud_rts = 0.
- Push/pop on full: FIFO full, out_aud_rtr = 1 and a new sample arriving at the same edge → sample accepted, fifo_count stays 4, ovf_flag stays 0.
- Reset mid-operation: two entries queued and one in stage 2, rstb low for one edge → out_aud_rts = 0, fifo_count = 0, flags = 0, and no stale sample emerges afterwards.
